spi2_xfer_ctrl: RTL and testbench
=================================

// Module: spi2_xfer_ctrl
// PURPOSE
//  Transaction sequencer sitting directly upstream of SPI2_master. The CPU bus
//  side writes words into a TX FIFO and reads received words from an RX FIFO.
//  This block drives the master's wr/din/bits/divider, waits for busy to drop,
//  captures dout into the RX FIFO and generates chip-select (cs_n) with setup/hold.
//  It keeps bits/divider frozen during a transfer; the master uses bits combinationally.
// PARAMETERS
//  FIFO_AW      2   log2 depth of each FIFO (depth = 2**FIFO_AW = 4 words)
//  CS_SETUP     2   clk cycles from cs_n falling to master wr pulse (>=1)
//  CS_HOLD      2   clk cycles from final capture to cs_n rising (>=1)
// PORTS
//  clk          in   1   master clock, all flops posedge
//  resetb       in   1   asynchronous reset, active low
//  tx_wr        in   1   push tx_data into TX FIFO (ignored when tx_full)
//  tx_data      in   32  word to send (LSBs used when bits<32)
//  tx_full      out  1   TX FIFO full
//  rx_rd        in   1   pop RX FIFO (ignored when rx_empty)
//  rx_data      out  32  RX FIFO head word, valid while !rx_empty
//  rx_empty     out  1   RX FIFO empty
//  cfg_divider  in   8   SCK divider, sampled at transaction start
//  cfg_bits     in   6   word length, sampled at transaction start
//  cfg_burst    in   1   1: keep cs_n low between back-to-back words
//  xfer_busy    out  1   FSM not in IDLE
//  cs_n         out  1   slave select, active low
//  m_wr         out  1   one-cycle write pulse to SPI2_master
//  m_din        out  32  word to SPI2_master
//  m_divider    out  8   held divider to SPI2_master
//  m_bits       out  6   held bit count to SPI2_master
//  m_busy       in   1   SPI2_master busy
//  m_dout       in   32  SPI2_master received word
// BEHAVIOUR
//  Reset: cs_n=1, m_wr=0, m_din=0, m_divider=0, m_bits=32, xfer_busy=0,
//    both FIFOs empty (tx_full=0, rx_empty=1), FSM=IDLE. Async reset mid-transfer
//    aborts it: cs_n rises immediately and FIFO contents are discarded.
//  Bits rule: cfg_bits==0 or >32 is latched as 32; 1..32 is latched unchanged.
//  FSM states:
//   IDLE   : !tx_empty -> SETUP. Latch m_divider/m_bits, drive cs_n=0, load cnt=CS_SETUP-1.
//   SETUP  : cnt==0 -> START, else decrement.
//   START  : m_wr=1 for exactly 1 cycle, m_din=TX head, TX pop this cycle -> ARM.
//   ARM    : 1 cycle; lets m_busy rise from the master's bit counter load -> WAIT.
//   WAIT   : m_busy==0 -> CAPT.
//   CAPT   : !rx_full: push m_dout into RX. Then:
//            cfg_burst & !tx_empty -> START (cs_n stays 0, m_bits/m_divider unchanged);
//            otherwise -> HOLD with cnt=CS_HOLD-1.
//            rx_full: stall in CAPT without pushing; no word is lost or overwritten.
//   HOLD   : cnt==0 -> IDLE with cs_n=1, else decrement.
//  Timing: the TX push at cycle 0 into an idle block gives cs_n=0 at cycle 1 and
//    m_wr at cycle 1+CS_SETUP.
//  m_bits/m_divider change only in IDLE->SETUP. They are stable for the whole burst.
//  Config changes during a burst take effect on the next SETUP.
//  FIFOs: simultaneous push+pop when full (TX) is push-ignored, pop done; when
//    empty (RX) pop ignored, push done; otherwise both act in the same cycle.
//    Pointers wrap modulo depth; count width FIFO_AW+1 distinguishes full/empty.
//  rx_data is registered-output-free: it equals the FIFO head combinationally.
//  xfer_busy = (state!=IDLE).
// STRUCTURE
//  Package spi2_pkg: state enum (IDLE,SETUP,START,ARM,WAIT,CAPT,HOLD),
//    BITS_MAX=6'd32, default FIFO_AW.
//  Sub-module spi2_fifo (params W=32, AW): synchronous FIFO, async active-low reset,
//    push/pop/full/empty/head. Instantiated twice (TX, RX). FSM and counters are top-level.
// TESTING (bench instantiates SPI2_master with miso looped to mosi)
//  1 Single word: cfg_bits=8, divider=0, push 0xA5 -> one m_wr; 8 SCK; rx_data=0xA5;
//    cs_n low from cycle 1 until CS_HOLD cycles after capture.
//  2 Burst: cfg_burst=1, push 0x11,0x22,0x33 -> cs_n stays 0 across all three;
//    RX pops 0x11,0x22,0x33 in order.
//  3 Non-burst: cfg_burst=0, two words -> cs_n pulses high between words for at least one cycle.
//  4 Bits clamp: cfg_bits=0 and cfg_bits=40, push 0xDEADBEEF -> m_bits=32; 32 SCK edges;
//    rx_data=0xDEADBEEF.
//  5 RX full: push 6 words, never pop -> FSM stalls in CAPT after 4 pushes; tx_full
//    behaviour correct; popping releases the stall and all 6 words arrive intact.
//  6 Mid-transfer changes: change cfg_bits 8->16 during a burst -> no effect until the
//    next SETUP. Assert resetb low mid-word -> cs_n=1 and FIFOs empty immediately.

Source files
------------

// File: rtl/spi2_pkg.sv
// Shared definitions for the SPI2 transaction sequencer: bus widths, FSM
// state encodings, latched-configuration payload and the bit-count clamp.
package spi2_pkg;

    localparam int unsigned DATA_W      = 32;
    localparam int unsigned BITS_W      = 6;
    localparam int unsigned DIV_W       = 8;
    localparam int unsigned FIFO_AW_DEF = 2;

    localparam logic [BITS_W-1:0] BITS_MAX = 6'd32;

    // Sequencer states
    localparam int unsigned ST_W = 3;
    localparam logic [ST_W-1:0] ST_IDLE  = 3'd0;
    localparam logic [ST_W-1:0] ST_SETUP = 3'd1;
    localparam logic [ST_W-1:0] ST_START = 3'd2;
    localparam logic [ST_W-1:0] ST_ARM   = 3'd3;
    localparam logic [ST_W-1:0] ST_WAIT  = 3'd4;
    localparam logic [ST_W-1:0] ST_CAPT  = 3'd5;
    localparam logic [ST_W-1:0] ST_HOLD  = 3'd6;

    // Configuration held towards SPI2_master for the whole transaction
    typedef struct packed {
        logic [DIV_W-1:0]  divider;
        logic [BITS_W-1:0] bits;
    } xfer_cfg_t;

    // Zero or oversize word lengths mean a full 32-bit word
    function automatic logic [BITS_W-1:0] clamp_bits(input logic [BITS_W-1:0] b);
        return ((b == '0) || (b > BITS_MAX)) ? BITS_MAX : b;
    endfunction

endpackage

// File: rtl/spi2_xfer_ctrl_if.sv
// Bundle of CPU-side FIFO/config signals and SPI2_master-side signals.
//  slave  : the sequencer's view (drives tx_full, rx_*, xfer_busy, cs_n, m_wr/din/divider/bits)
//  master : the surrounding system's view (drives tx_*, rx_rd, cfg_*, m_busy, m_dout)
interface spi2_xfer_ctrl_if;
    import spi2_pkg::*;

    logic              tx_wr;
    logic [DATA_W-1:0] tx_data;
    logic              tx_full;
    logic              rx_rd;
    logic [DATA_W-1:0] rx_data;
    logic              rx_empty;
    logic [DIV_W-1:0]  cfg_divider;
    logic [BITS_W-1:0] cfg_bits;
    logic              cfg_burst;
    logic              xfer_busy;
    logic              cs_n;
    logic              m_wr;
    logic [DATA_W-1:0] m_din;
    logic [DIV_W-1:0]  m_divider;
    logic [BITS_W-1:0] m_bits;
    logic              m_busy;
    logic [DATA_W-1:0] m_dout;

    modport slave (
        input  tx_wr, tx_data, rx_rd, cfg_divider, cfg_bits, cfg_burst, m_busy, m_dout,
        output tx_full, rx_data, rx_empty, xfer_busy, cs_n, m_wr, m_din, m_divider, m_bits
    );

    modport master (
        output tx_wr, tx_data, rx_rd, cfg_divider, cfg_bits, cfg_burst, m_busy, m_dout,
        input  tx_full, rx_data, rx_empty, xfer_busy, cs_n, m_wr, m_din, m_divider, m_bits
    );

endinterface

// File: rtl/spi2_fifo.sv
// Synchronous FIFO, depth 2**AW, head word visible combinationally.
//  push/din : write (ignored when full)     pop : read (ignored when empty)
//  full/empty : occupancy flags             head : oldest stored word
module spi2_fifo #(
    parameter int unsigned W  = 32,
    parameter int unsigned AW = 2
) (
    input  logic         clk,
    input  logic         resetb,
    input  logic         push,
    input  logic [W-1:0] din,
    input  logic         pop,
    output logic         full,
    output logic         empty,
    output logic [W-1:0] head
);

    localparam int unsigned DEPTH = 1 << AW;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          push_ok;
    logic          pop_ok;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign head    = mem[rd_ptr];
    assign push_ok = push & ~full;
    assign pop_ok  = pop & ~empty;

    // Pointer and occupancy tracking; pointers wrap naturally at depth
    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + AW'(1);
            if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
            count <= count + (AW+1)'(push_ok) - (AW+1)'(pop_ok);
        end
    end

    // Storage needs no reset: occupancy alone decides what is valid
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/spi2_xfer_ctrl.sv
// Transaction sequencer in front of SPI2_master: feeds TX FIFO words to the
// master one at a time, frames them with cs_n setup/hold, and stores each
// received word in the RX FIFO.
//  clk, resetb : clock and asynchronous active-low reset
//  bus         : CPU FIFO/config side and SPI2_master side (slave modport)
module spi2_xfer_ctrl
    import spi2_pkg::*;
#(
    parameter int unsigned FIFO_AW  = FIFO_AW_DEF,
    parameter int unsigned CS_SETUP = 2,
    parameter int unsigned CS_HOLD  = 2
) (
    input logic              clk,
    input logic              resetb,
    spi2_xfer_ctrl_if.slave  bus
);

    localparam int unsigned CNT_W = 8;

    logic [ST_W-1:0]   state,    state_d;
    logic [CNT_W-1:0]  cnt,      cnt_d;
    logic              cs_n_q,   cs_n_d;
    logic              m_wr_q,   m_wr_d;
    logic [DATA_W-1:0] m_din_q,  m_din_d;
    xfer_cfg_t         cfg_q,    cfg_d;
    logic              xfer_busy_q;

    logic              tx_pop;
    logic              tx_full;
    logic              tx_empty;
    logic [DATA_W-1:0] tx_head;
    logic              rx_push;
    logic              rx_full;
    logic              rx_empty;
    logic [DATA_W-1:0] rx_head;

    spi2_fifo #(.W(DATA_W), .AW(FIFO_AW)) u_tx_fifo (
        .clk    (clk),
        .resetb (resetb),
        .push   (bus.tx_wr),
        .din    (bus.tx_data),
        .pop    (tx_pop),
        .full   (tx_full),
        .empty  (tx_empty),
        .head   (tx_head)
    );

    spi2_fifo #(.W(DATA_W), .AW(FIFO_AW)) u_rx_fifo (
        .clk    (clk),
        .resetb (resetb),
        .push   (rx_push),
        .din    (bus.m_dout),
        .pop    (bus.rx_rd),
        .full   (rx_full),
        .empty  (rx_empty),
        .head   (rx_head)
    );

    assign bus.tx_full   = tx_full;
    assign bus.rx_empty  = rx_empty;
    assign bus.rx_data   = rx_head;
    assign bus.xfer_busy = xfer_busy_q;
    assign bus.cs_n      = cs_n_q;
    assign bus.m_wr      = m_wr_q;
    assign bus.m_din     = m_din_q;
    assign bus.m_divider = cfg_q.divider;
    assign bus.m_bits    = cfg_q.bits;

    // State and registered outputs
    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            state       <= ST_IDLE;
            cnt         <= '0;
            cs_n_q      <= 1'b1;
            m_wr_q      <= 1'b0;
            m_din_q     <= '0;
            cfg_q       <= '{divider: '0, bits: BITS_MAX};
            xfer_busy_q <= 1'b0;
        end else begin
            state       <= state_d;
            cnt         <= cnt_d;
            cs_n_q      <= cs_n_d;
            m_wr_q      <= m_wr_d;
            m_din_q     <= m_din_d;
            cfg_q       <= cfg_d;
            xfer_busy_q <= (state_d != ST_IDLE);
        end
    end

    // Next-state and output decode; m_wr is only ever raised on entry to START
    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        cs_n_d  = cs_n_q;
        m_wr_d  = 1'b0;
        m_din_d = m_din_q;
        cfg_d   = cfg_q;
        tx_pop  = 1'b0;
        rx_push = 1'b0;

        case (state)
            ST_IDLE: begin
                if (!tx_empty) begin
                    state_d       = ST_SETUP;
                    cfg_d.divider = bus.cfg_divider;
                    cfg_d.bits    = clamp_bits(bus.cfg_bits);
                    cs_n_d        = 1'b0;
                    cnt_d         = CNT_W'(CS_SETUP - 1);
                end
            end
            ST_SETUP: begin
                if (cnt == '0) begin
                    state_d = ST_START;
                    m_wr_d  = 1'b1;
                    m_din_d = tx_head;
                end else begin
                    cnt_d = cnt - CNT_W'(1);
                end
            end
            ST_START: begin
                tx_pop  = 1'b1;
                state_d = ST_ARM;
            end
            ST_ARM: begin
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (!bus.m_busy) state_d = ST_CAPT;
            end
            ST_CAPT: begin
                // A full RX FIFO holds the sequencer here so no word is dropped
                if (!rx_full) begin
                    rx_push = 1'b1;
                    if (bus.cfg_burst && !tx_empty) begin
                        state_d = ST_START;
                        m_wr_d  = 1'b1;
                        m_din_d = tx_head;
                    end else begin
                        state_d = ST_HOLD;
                        cnt_d   = CNT_W'(CS_HOLD - 1);
                    end
                end
            end
            ST_HOLD: begin
                if (cnt == '0) begin
                    state_d = ST_IDLE;
                    cs_n_d  = 1'b1;
                end else begin
                    cnt_d = cnt - CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                cs_n_d  = 1'b1;
            end
        endcase
    end

endmodule

// File: tb/tb_spi2_xfer_ctrl.sv
// Bench for spi2_xfer_ctrl with a behavioural SPI2_master (MISO looped to MOSI).
module tb_spi2_xfer_ctrl;
    import spi2_pkg::*;

    localparam int unsigned CS_SETUP_T = 2;
    localparam int unsigned CS_HOLD_T  = 2;
    localparam int          BOUND      = 3000;

    logic clk;
    logic resetb;

    spi2_xfer_ctrl_if bus();

    spi2_xfer_ctrl #(
        .FIFO_AW  (2),
        .CS_SETUP (CS_SETUP_T),
        .CS_HOLD  (CS_HOLD_T)
    ) dut (
        .clk    (clk),
        .resetb (resetb),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural master: busy for 2*bits*(divider+1) clocks, returns din masked to bits
    logic        sck;
    logic [31:0] m_sh;
    int          hp;
    int          dcnt;
    int          rises;

    function automatic logic [31:0] bit_mask(input logic [5:0] b);
        logic [31:0] one;
        one = 32'h1;
        return (b >= 6'd32) ? 32'hFFFF_FFFF : ((one << b) - 32'h1);
    endfunction

    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            bus.m_busy <= 1'b0;
            bus.m_dout <= '0;
            sck        <= 1'b0;
            m_sh       <= '0;
            hp         <= 0;
            dcnt       <= 0;
            rises      <= 0;
        end else if (bus.m_wr && !bus.m_busy) begin
            bus.m_busy <= 1'b1;
            m_sh       <= bus.m_din;
            hp         <= 2 * int'(bus.m_bits);
            dcnt       <= 0;
            sck        <= 1'b0;
            rises      <= 0;
        end else if (bus.m_busy) begin
            if (dcnt == int'(bus.m_divider)) begin
                dcnt <= 0;
                sck  <= ~sck;
                if (!sck) rises <= rises + 1;
                if (hp == 1) begin
                    bus.m_busy <= 1'b0;
                    bus.m_dout <= m_sh & bit_mask(bus.m_bits);
                end
                hp <= hp - 1;
            end else begin
                dcnt <= dcnt + 1;
            end
        end
    end

    int   n_cmp;
    int   n_bad;
    int   falls;
    int   rises_cs;
    int   wrs;
    logic [5:0] max_bits;
    logic prev_cs;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // One clock, sampled at the falling edge, with cs_n/m_wr activity counted
    task automatic tick();
        @(negedge clk);
        if (prev_cs && !bus.cs_n) falls++;
        if (!prev_cs && bus.cs_n) rises_cs++;
        if (bus.m_wr) wrs++;
        if (!bus.cs_n && (bus.m_bits > max_bits)) max_bits = bus.m_bits;
        prev_cs = bus.cs_n;
    endtask

    task automatic clear_mon();
        falls    = 0;
        rises_cs = 0;
        wrs      = 0;
        max_bits = '0;
    endtask

    task automatic push(input logic [31:0] d);
        int k;
        k = 0;
        while (bus.tx_full && k < BOUND) begin
            tick();
            k++;
        end
        check("push_wait", 32'(k < BOUND), 32'd1);
        bus.tx_wr   = 1'b1;
        bus.tx_data = d;
        tick();
        bus.tx_wr   = 1'b0;
    endtask

    task automatic wait_xfers(input int n);
        int k;
        k = 0;
        while (!(wrs >= n && !bus.xfer_busy) && k < BOUND) begin
            tick();
            k++;
        end
        check("xfer_timeout", 32'(k < BOUND), 32'd1);
    endtask

    task automatic pop_check(input string name, input logic [31:0] exp);
        int k;
        k = 0;
        while (bus.rx_empty && k < BOUND) begin
            tick();
            k++;
        end
        check(name, bus.rx_data, exp);
        bus.rx_rd = 1'b1;
        tick();
        bus.rx_rd = 1'b0;
    endtask

    typedef struct {
        logic [5:0]  bits;
        logic [7:0]  div;
        logic [31:0] data;
        logic [31:0] exp_rx;
        logic [5:0]  exp_bits;
    } vec_t;

    vec_t vecs[8];

    initial begin
        int k;
        int first_cs;
        int first_wr;
        int first_rx;
        int cs_rise;

        vecs[0] = '{6'd8,  8'd0, 32'h0000_00A5, 32'h0000_00A5, 6'd8};
        vecs[1] = '{6'd0,  8'd0, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 6'd32};
        vecs[2] = '{6'd40, 8'd0, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 6'd32};
        vecs[3] = '{6'd16, 8'd1, 32'h1234_ABCD, 32'h0000_ABCD, 6'd16};
        vecs[4] = '{6'd1,  8'd2, 32'hFFFF_FFFE, 32'h0000_0000, 6'd1};
        vecs[5] = '{6'd32, 8'd0, 32'h5A5A_0F0F, 32'h5A5A_0F0F, 6'd32};
        vecs[6] = '{6'd33, 8'd3, 32'h8000_0001, 32'h8000_0001, 6'd32};
        vecs[7] = '{6'd12, 8'd0, 32'hFFFF_F123, 32'h0000_0123, 6'd12};

        n_cmp           = 0;
        n_bad           = 0;
        prev_cs         = 1'b1;
        clear_mon();
        resetb          = 1'b0;
        bus.tx_wr       = 1'b0;
        bus.tx_data     = '0;
        bus.rx_rd       = 1'b0;
        bus.cfg_divider = '0;
        bus.cfg_bits    = '0;
        bus.cfg_burst   = 1'b0;

        tick();
        tick();
        check("rst_cs_n",      32'(bus.cs_n),      32'd1);
        check("rst_m_wr",      32'(bus.m_wr),      32'd0);
        check("rst_m_din",     bus.m_din,          32'd0);
        check("rst_m_divider", 32'(bus.m_divider), 32'd0);
        check("rst_m_bits",    32'(bus.m_bits),    32'd32);
        check("rst_xfer_busy", 32'(bus.xfer_busy), 32'd0);
        check("rst_tx_full",   32'(bus.tx_full),   32'd0);
        check("rst_rx_empty",  32'(bus.rx_empty),  32'd1);
        resetb = 1'b1;
        tick();

        // Single word with cycle-exact cs_n / m_wr framing
        bus.cfg_bits    = 6'd8;
        bus.cfg_divider = 8'd0;
        clear_mon();
        first_cs = -1; first_wr = -1; first_rx = -1; cs_rise = -1;
        k = 0;
        bus.tx_wr   = 1'b1;
        bus.tx_data = 32'h0000_00A5;
        tick();
        bus.tx_wr   = 1'b0;
        while (cs_rise < 0 && k < BOUND) begin
            if (!bus.cs_n && first_cs < 0) first_cs = k;
            if (bus.m_wr && first_wr < 0) first_wr = k;
            if (!bus.rx_empty && first_rx < 0) first_rx = k;
            if (first_cs >= 0 && bus.cs_n && cs_rise < 0) cs_rise = k;
            if (cs_rise < 0) begin
                tick();
                k++;
            end
        end
        check("single_timeout",  32'(k < BOUND),          32'd1);
        check("single_cs_fall",  32'(first_cs),           32'd1);
        check("single_wr_cycle", 32'(first_wr),           32'(1 + CS_SETUP_T));
        check("single_cs_hold",  32'(cs_rise - first_rx), 32'(CS_HOLD_T));
        check("single_wr_count", 32'(wrs),                32'd1);
        check("single_sck",      32'(rises),              32'd8);
        pop_check("single_rx", 32'h0000_00A5);

        // Table of single-word transfers
        for (int i = 0; i < 8; i++) begin
            bus.cfg_bits    = vecs[i].bits;
            bus.cfg_divider = vecs[i].div;
            bus.cfg_burst   = 1'b0;
            clear_mon();
            push(vecs[i].data);
            wait_xfers(1);
            check($sformatf("vec%0d_m_bits", i),    32'(bus.m_bits),    32'(vecs[i].exp_bits));
            check($sformatf("vec%0d_m_divider", i), 32'(bus.m_divider), 32'(vecs[i].div));
            check($sformatf("vec%0d_sck", i),       32'(rises),         32'(vecs[i].exp_bits));
            check($sformatf("vec%0d_cs", i),        32'(falls * 16 + rises_cs), 32'h11);
            pop_check($sformatf("vec%0d_rx", i), vecs[i].exp_rx);
            check($sformatf("vec%0d_rx_empty", i),  32'(bus.rx_empty),  32'd1);
        end

        // Burst of three with a word-length change mid-burst
        bus.cfg_bits    = 6'd8;
        bus.cfg_divider = 8'd0;
        bus.cfg_burst   = 1'b1;
        clear_mon();
        push(32'h0000_0111);
        push(32'h0000_0222);
        push(32'h0000_0333);
        k = 0;
        while (wrs < 1 && k < BOUND) begin
            tick();
            k++;
        end
        bus.cfg_bits = 6'd16;
        wait_xfers(3);
        check("burst_cs_falls", 32'(falls),    32'd1);
        check("burst_cs_rises", 32'(rises_cs), 32'd1);
        check("burst_wrs",      32'(wrs),      32'd3);
        check("burst_m_bits",   32'(max_bits), 32'd8);
        pop_check("burst_rx0", 32'h0000_0011);
        pop_check("burst_rx1", 32'h0000_0022);
        pop_check("burst_rx2", 32'h0000_0033);
        bus.cfg_burst = 1'b0;
        clear_mon();
        push(32'h0000_0444);
        wait_xfers(1);
        check("newcfg_m_bits", 32'(bus.m_bits), 32'd16);
        pop_check("newcfg_rx", 32'h0000_0444);

        // Non-burst: cs_n returns high between words
        bus.cfg_bits    = 6'd4;
        bus.cfg_divider = 8'd1;
        clear_mon();
        push(32'h0000_00AB);
        push(32'h0000_00CD);
        wait_xfers(2);
        check("nonburst_cs_falls", 32'(falls),    32'd2);
        check("nonburst_cs_rises", 32'(rises_cs), 32'd2);
        pop_check("nonburst_rx0", 32'h0000_000B);
        pop_check("nonburst_rx1", 32'h0000_000D);

        // RX full stall with six words queued
        bus.cfg_divider = 8'd0;
        clear_mon();
        push(32'h0000_00F1);
        push(32'h0000_00F2);
        push(32'h0000_00F3);
        push(32'h0000_00F4);
        check("txfull_after4", 32'(bus.tx_full), 32'd1);
        push(32'h0000_00F5);
        push(32'h0000_00F6);
        for (int c = 0; c < 300; c++) tick();
        check("stall_busy",     32'(bus.xfer_busy), 32'd1);
        check("stall_cs_n",     32'(bus.cs_n),      32'd0);
        check("stall_wrs",      32'(wrs),           32'd5);
        check("stall_rx_empty", 32'(bus.rx_empty),  32'd0);
        for (int i = 1; i <= 6; i++) begin
            pop_check($sformatf("stall_rx%0d", i), 32'(i));
        end
        wait_xfers(6);
        check("stall_total_wrs", 32'(wrs),          32'd6);
        check("stall_rx_drain",  32'(bus.rx_empty), 32'd1);

        // Asynchronous reset in the middle of a burst
        bus.cfg_bits  = 6'd4;
        bus.cfg_burst = 1'b1;
        clear_mon();
        push(32'h0000_0001);
        push(32'h0000_0002);
        push(32'h0000_0003);
        k = 0;
        while (wrs < 2 && k < BOUND) begin
            tick();
            k++;
        end
        check("prerst_rx_empty", 32'(bus.rx_empty), 32'd0);
        check("prerst_cs_n",     32'(bus.cs_n),     32'd0);
        resetb = 1'b0;
        #1;
        check("midrst_cs_n",      32'(bus.cs_n),      32'd1);
        check("midrst_rx_empty",  32'(bus.rx_empty),  32'd1);
        check("midrst_tx_full",   32'(bus.tx_full),   32'd0);
        check("midrst_xfer_busy", 32'(bus.xfer_busy), 32'd0);
        check("midrst_m_bits",    32'(bus.m_bits),    32'd32);
        tick();
        tick();
        resetb        = 1'b1;
        bus.cfg_burst = 1'b0;
        bus.cfg_bits  = 6'd8;
        tick();
        clear_mon();
        push(32'h0000_005C);
        wait_xfers(1);
        check("postrst_wrs", 32'(wrs), 32'd1);
        pop_check("postrst_rx", 32'h0000_005C);
        check("postrst_rx_empty", 32'(bus.rx_empty), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
